// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL lock detector.
//   state_t      : lock FSM states
//   fe_t         : window verdict encoding driven on Freq_Err
//   freq_verdict : classifies a measured period against ratio +/- tolerance
//   max_u        : unsigned max, used for counter sizing
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FE_GOOD = 2'b00,
    FE_SLOW = 2'b01,
    FE_FAST = 2'b10
  } fe_t;

  // The lower bound is written as count + tol < mult so it cannot underflow when tol > mult.
  function automatic fe_t freq_verdict(input int unsigned count,
                                       input int unsigned mult,
                                       input int unsigned tol);
    fe_t v;
    if (count + tol < mult)      v = FE_SLOW;
    else if (count > mult + tol) v = FE_FAST;
    else                         v = FE_GOOD;
    return v;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_detector_if.sv
// Signal bundle between the lock detector and its user.
//   Ref_Clk, Enable                                     : user -> detector
//   Locked, Meas_Valid, Meas_Count, Freq_Err, Ref_Lost : detector -> user
// master = user side (drives Ref_Clk/Enable), slave = detector side.
interface pll_lock_detector_if #(
  parameter int unsigned CNT_W = 8
);
  logic             Ref_Clk;
  logic             Enable;
  logic             Locked;
  logic             Meas_Valid;
  logic [CNT_W-1:0] Meas_Count;
  logic [1:0]       Freq_Err;
  logic             Ref_Lost;

  modport master (
    output Ref_Clk, Enable,
    input  Locked, Meas_Valid, Meas_Count, Freq_Err, Ref_Lost
  );

  modport slave (
    input  Ref_Clk, Enable,
    output Locked, Meas_Valid, Meas_Count, Freq_Err, Ref_Lost
  );
endinterface

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous reference clock into the CLK domain and turns each rising edge
// into a registered one-cycle tick, three CLK edges after the rise.
//   CLK    : fast clock
//   RST    : asynchronous active-high reset
//   i_ref  : raw reference clock, sampled as data
//   o_tick : one-cycle pulse per reference rising edge
module ref_edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic i_ref,
  output logic o_tick
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_tick;

  // Two-flop synchronizer, previous-value flop and registered rising-edge pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_s1   <= i_ref;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_tick <= r_s2 & ~r_prev;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/pll_lock_detector.sv
// PLL frequency lock detector. Counts CLK cycles per reference period, grades every
// window against MULT_RATIO +/- TOL and runs a lock/unlock FSM on consecutive verdicts.
//   CLK, RST : fast clock, asynchronous active-high reset
//   bus      : slave side of pll_lock_detector_if (Ref_Clk/Enable in; Locked,
//              Meas_Valid, Meas_Count, Freq_Err, Ref_Lost out, all registered)
module pll_lock_detector
  import pll_pkg::*;
#(
  parameter int unsigned MULT_RATIO   = 50,
  parameter int unsigned TOL          = 2,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned TIMEOUT      = 2 * MULT_RATIO
) (
  input logic               CLK,
  input logic               RST,
  pll_lock_detector_if.slave bus
);

  localparam int unsigned GB_W = $clog2(max_u(LOCK_COUNT, UNLOCK_COUNT) + 1);

  logic             w_tick;
  state_t           r_state,  w_state;
  logic [CNT_W-1:0] r_cnt,    w_cnt;
  logic [GB_W-1:0]  r_good,   w_good;
  logic [GB_W-1:0]  r_bad,    w_bad;
  logic             r_locked, w_locked;
  logic             r_valid,  w_valid;
  logic [CNT_W-1:0] r_meas,   w_meas;
  fe_t              r_ferr,   w_ferr;
  logic             r_lost,   w_lost;
  logic             w_close;
  logic [CNT_W-1:0] w_win;
  fe_t              w_win_fe;

  ref_edge_sync u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .i_ref  (bus.Ref_Clk),
    .o_tick (w_tick)
  );

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_good   <= '0;
      r_bad    <= '0;
      r_locked <= 1'b0;
      r_valid  <= 1'b0;
      r_meas   <= '0;
      r_ferr   <= FE_GOOD;
      r_lost   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_good   <= w_good;
      r_bad    <= w_bad;
      r_locked <= w_locked;
      r_valid  <= w_valid;
      r_meas   <= w_meas;
      r_ferr   <= w_ferr;
      r_lost   <= w_lost;
    end
  end

  // Next-state, window close and verdict logic.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_good   = r_good;
    w_bad    = r_bad;
    w_locked = r_locked;
    w_valid  = 1'b0;
    w_meas   = r_meas;
    w_ferr   = r_ferr;
    w_lost   = r_lost;
    w_close  = 1'b0;
    w_win    = r_meas;
    w_win_fe = FE_GOOD;

    // A tick outranks a timeout landing in the same cycle.
    if (w_tick) begin
      w_close  = 1'b1;
      w_win    = CNT_W'(r_cnt + CNT_W'(1));
      w_win_fe = freq_verdict(32'(w_win), MULT_RATIO, TOL);
    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
      w_close  = 1'b1;
      w_win    = CNT_W'(TIMEOUT);
      w_win_fe = FE_SLOW;
    end

    if (!bus.Enable) begin
      // Meas_Count and Freq_Err keep their last values while disabled.
      w_state  = IDLE;
      w_cnt    = '0;
      w_good   = '0;
      w_bad    = '0;
      w_locked = 1'b0;
      w_lost   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state = ARM;
          w_cnt   = '0;
        end
        ARM: begin
          // First tick only starts the period counter.
          w_cnt = '0;
          if (w_tick) begin
            w_state = MEASURE;
            w_lost  = 1'b0;
          end
        end
        MEASURE, LOCKED: begin
          // Closing at TIMEOUT keeps the counter from ever passing it.
          w_cnt = w_close ? '0 : CNT_W'(r_cnt + CNT_W'(1));
          if (w_close) begin
            w_valid = 1'b1;
            w_meas  = w_win;
            w_ferr  = w_win_fe;
            w_lost  = !w_tick;
            if (r_state == MEASURE) begin
              if (w_win_fe != FE_GOOD) begin
                w_good = '0;
              end else if (32'(r_good) + 32'd1 >= LOCK_COUNT) begin
                w_state  = LOCKED;
                w_locked = 1'b1;
                w_good   = '0;
                w_bad    = '0;
              end else begin
                w_good = GB_W'(32'(r_good) + 32'd1);
              end
            end else begin
              if (w_win_fe == FE_GOOD) begin
                w_bad = '0;
              end else if (32'(r_bad) + 32'd1 >= UNLOCK_COUNT) begin
                w_state  = MEASURE;
                w_locked = 1'b0;
                w_good   = '0;
                w_bad    = '0;
              end else begin
                w_bad = GB_W'(32'(r_bad) + 32'd1);
              end
            end
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign bus.Locked     = r_locked;
  assign bus.Meas_Valid = r_valid;
  assign bus.Meas_Count = r_meas;
  assign bus.Freq_Err   = r_ferr;
  assign bus.Ref_Lost   = r_lost;

endmodule

// File: tb/tb_pll_lock_detector.sv
// Directed bench for pll_lock_detector: acquisition, tolerance edges, unlock/relock,
// reference loss, asynchronous reset while locked, and enable drop/re-arm.
module tb_pll_lock_detector;
  import pll_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  pll_lock_detector_if #(.CNT_W(8)) bus ();

  pll_lock_detector dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;

  // Latched copy of the outputs at every Meas_Valid strobe.
  int ev_cnt   = 0;
  int last_mc  = 0;
  int last_fe  = 0;
  int last_lk  = 0;
  int last_lo  = 0;

  always @(negedge CLK) begin
    if (bus.Meas_Valid === 1'b1) begin
      ev_cnt  <= ev_cnt + 1;
      last_mc <= int'(bus.Meas_Count);
      last_fe <= int'(bus.Freq_Err);
      last_lk <= int'(bus.Locked);
      last_lo <= int'(bus.Ref_Lost);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One reference period of n CLK cycles; rises are exactly n posedges apart.
  task automatic prd(input int n);
    bus.Ref_Clk = 1'b1;
    repeat (n / 2) @(posedge CLK);
    #1 bus.Ref_Clk = 1'b0;
    repeat (n - n / 2) @(posedge CLK);
    #1;
  endtask

  // Period whose rising edge is only expected to arm the detector.
  task automatic arm(input int n);
    int e0;
    e0 = ev_cnt;
    step++;
    prd(n);
    check_eq($sformatf("s%0d_arm_no_valid", step), 32'(ev_cnt - e0), 32'd0);
  endtask

  // Period of length n; its rising edge closes the previous window with these results.
  task automatic win(input int n, input int mc, input int fe, input int lk);
    int e0;
    e0 = ev_cnt;
    step++;
    prd(n);
    check_eq($sformatf("s%0d_valid_cnt", step), 32'(ev_cnt - e0), 32'd1);
    check_eq($sformatf("s%0d_meas_count", step), 32'(last_mc), 32'(mc));
    check_eq($sformatf("s%0d_freq_err", step), 32'(last_fe), 32'(fe));
    check_eq($sformatf("s%0d_locked", step), 32'(last_lk), 32'(lk));
    check_eq($sformatf("s%0d_ref_lost", step), 32'(last_lo), 32'd0);
  endtask

  task automatic wait_ev(input string tag, input int budget);
    int e0;
    int k;
    e0 = ev_cnt;
    k  = 0;
    while (ev_cnt == e0 && k < budget) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check_eq({tag, "_seen"}, 32'(ev_cnt - e0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_locked"}, 32'(bus.Locked), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.Meas_Valid), 32'd0);
    check_eq({tag, "_count"}, 32'(bus.Meas_Count), 32'd0);
    check_eq({tag, "_ferr"}, 32'(bus.Freq_Err), 32'd0);
    check_eq({tag, "_lost"}, 32'(bus.Ref_Lost), 32'd0);
  endtask

  // Arm plus four good 50-cycle windows; Locked only on the fourth.
  task automatic acquire();
    arm(50);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 1);
  endtask

  initial begin
    int e0;
    RST         = 1'b1;
    bus.Ref_Clk = 1'b0;
    bus.Enable  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 bus.Enable = 1'b1;
    @(posedge CLK);
    #1;

    // Clean acquisition at the nominal ratio.
    acquire();

    // While locked: one bad window is tolerated, two in a row unlock.
    win(55, 50, FE_GOOD, 1);
    win(50, 55, FE_FAST, 1);
    win(55, 50, FE_GOOD, 1);
    win(55, 55, FE_FAST, 1);
    win(48, 55, FE_FAST, 0);

    // Tolerance edges during acquisition; a bad window restarts the count.
    win(52, 48, FE_GOOD, 0);
    win(47, 52, FE_GOOD, 0);
    win(53, 47, FE_SLOW, 0);
    win(50, 53, FE_FAST, 0);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 1);

    // Reference stops while locked.
    wait_ev("timeout1", 160);
    check_eq("timeout1_count", 32'(last_mc), 32'd100);
    check_eq("timeout1_ferr", 32'(last_fe), 32'(FE_SLOW));
    check_eq("timeout1_lost", 32'(last_lo), 32'd1);
    check_eq("timeout1_locked", 32'(last_lk), 32'd1);
    wait_ev("timeout2", 160);
    check_eq("timeout2_count", 32'(last_mc), 32'd100);
    check_eq("timeout2_lost", 32'(last_lo), 32'd1);
    check_eq("timeout2_locked", 32'(last_lk), 32'd0);

    // Restart: first tick closes a short window and clears Ref_Lost.
    e0 = ev_cnt;
    prd(50);
    check_eq("restart_valid_cnt", 32'(ev_cnt - e0), 32'd1);
    check_eq("restart_lost", 32'(last_lo), 32'd0);
    check_eq("restart_ferr", 32'(last_fe), 32'(FE_SLOW));
    check_eq("restart_locked", 32'(last_lk), 32'd0);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 0);
    win(50, 50, FE_GOOD, 1);
    check_eq("prereset_locked", 32'(bus.Locked), 32'd1);

    // Asynchronous reset between clock edges while locked.
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    acquire();

    // Enable dropped while locked.
    bus.Enable = 1'b0;
    @(posedge CLK);
    #1;
    check_eq("dis_locked", 32'(bus.Locked), 32'd0);
    check_eq("dis_lost", 32'(bus.Ref_Lost), 32'd0);
    e0 = ev_cnt;
    prd(50);
    prd(50);
    check_eq("dis_no_valid", 32'(ev_cnt - e0), 32'd0);
    check_eq("dis_count_kept", 32'(bus.Meas_Count), 32'd50);

    // Re-enable: an ARM tick comes before any measurement.
    bus.Enable = 1'b1;
    arm(50);
    win(50, 50, FE_GOOD, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_detector.md
Name: pll_lock_detector

Overview:
- Checks the behavioural PLL on the TX path from the other end. It runs on the multiplied high-speed clock, samples the reference clock as data, and counts how many fast-clock cycles fall in each reference period.
- The measured ratio is compared against the expected multiplication factor within a tolerance. Consecutive good or bad windows drive a lock/unlock state machine.
- Locked gates serializer start-up in TX top level.

Parameters:
- MULT_RATIO, 50, expected CLK cycles per Ref_Clk period.
- TOL, 2, allowed absolute deviation from MULT_RATIO, inclusive.
- LOCK_COUNT, 4, consecutive good windows needed to assert Locked.
- UNLOCK_COUNT, 2, consecutive bad windows needed to drop Locked.
- CNT_W, 8, width of the period counter. Must hold TIMEOUT.
- TIMEOUT, 2*MULT_RATIO, cycle count without a ref edge that declares a bad window and Ref_Lost.

Ports:
- CLK  in  1  fast clock, the multiplied PLL output.
- RST  in  1  asynchronous, active-high reset.
- Ref_Clk  in  1  reference clock, asynchronous to CLK, sampled as data.
- Enable  in  1  detector enable, synchronous to CLK.
- Locked  out  1  PLL frequency lock indication.
- Meas_Valid  out  1  one-cycle strobe when Meas_Count/Freq_Err update.
- Meas_Count  out  CNT_W  last measured CLK cycles per ref period.
- Freq_Err  out  2  last window verdict: 00 good, 01 CLK slow (count below range), 10 CLK fast (count above range).
- Ref_Lost  out  1  no ref edge within TIMEOUT cycles.

Behaviour:
- Reset (async, any time, including mid-lock):
  - All outputs 0; state IDLE; all counters 0; synchronizer flops 0.
- Synchronizer:
  - Ref_Clk passes through 2 flops, then a registered-previous edge detect.
  - ref_tick is a 1-cycle pulse; a Ref_Clk rise produces ref_tick 3 CLK edges later.
- Period counter cnt_q:
  - On ref_tick: cnt_q <= 0.
  - Otherwise: cnt_q <= cnt_q+1, saturating at TIMEOUT.
  - With ticks exactly MULT_RATIO cycles apart, measured value = cnt_q+1 = MULT_RATIO.
- Window close, only in states MEASURE or LOCKED:
  - On ref_tick: Meas_Count <= cnt_q+1.
  - On cnt_q reaching TIMEOUT with no tick: Meas_Count <= TIMEOUT, Freq_Err <= 01, Ref_Lost <= 1, cnt_q <= 0.
  - Meas_Valid pulses 1 cycle after the close, with Meas_Count/Freq_Err updated in the same cycle.
- Window verdict:
  - good iff MULT_RATIO-TOL <= count <= MULT_RATIO+TOL.
  - count below range -> 01; above range -> 10.
- Ref_Lost clears on the next ref_tick.
- If ref_tick and timeout occur in the same cycle, ref_tick wins.
- FSM:
  - IDLE: Enable=0. Counters held 0, Locked=0. Enable=1 -> ARM.
  - ARM: wait for the first ref_tick, which only starts the counter and produces no verdict -> MEASURE.
  - MEASURE: a good window increments good_cnt; a bad window clears good_cnt. When good_cnt reaches LOCK_COUNT -> LOCKED, and Locked=1 in the cycle Meas_Valid of that window is high.
  - LOCKED: a bad window increments bad_cnt; a good window clears bad_cnt. When bad_cnt reaches UNLOCK_COUNT -> MEASURE, Locked=0 in the same cycle as that Meas_Valid, and good_cnt=0.
  - Enable=0 in any state -> IDLE next cycle. Locked, Ref_Lost and counters clear; Meas_Count keeps its last value.
- Locked is registered and glitch-free.
- good_cnt/bad_cnt are sized clog2(max(LOCK_COUNT,UNLOCK_COUNT)+1) and never wrap.

Decomposition:
- Package pll_pkg:
  - State enum: IDLE, ARM, MEASURE, LOCKED.
  - Freq_Err encodings: FE_GOOD, FE_SLOW, FE_FAST.
- Sub-module ref_edge_sync: 2-flop synchronizer plus rising-edge pulse, with CLK/RST and async reset.
- FSM, counters and compare stay in the top level.

Test Plan:
- Ref period = 50 CLK, Enable=1 after reset:
  - First tick arms.
  - Ticks 2–5 give Meas_Count=50, Freq_Err=00.
  - Locked rises with the 4th Meas_Valid, never earlier.
- Tolerance boundaries:
  - Periods of 48 and 52 -> Freq_Err=00.
  - 47 -> 01; 53 -> 10.
  - One bad window during acquisition restarts the 4-window count.
- While locked:
  - A single 55-cycle window -> Locked stays 1.
  - Two consecutive 55-cycle windows -> Locked=0 on the 2nd Meas_Valid.
  - Then 4 good windows relock.
- Ref_Clk stopped while locked:
  - After 100 cycles: Ref_Lost=1, Meas_Count=100, Freq_Err=01.
  - After the second timeout: Locked=0.
  - Restarting Ref_Clk clears Ref_Lost on the first tick.
- RST asserted mid-LOCKED, between clock edges:
  - All outputs 0 immediately, without waiting for a CLK edge.
  - After release: full ARM + 4 windows needed to relock.
- Enable dropped while LOCKED:
  - Locked=0 next cycle; state IDLE; no Meas_Valid while disabled.
  - Re-enable requires an ARM tick before any measurement.
